// File: rtl/alu_issue_ctrl.sv
// Issue controller for a combinational ALU: buffers requests in a small FIFO,
// presents one operand set at a time and holds each result until accepted.
module alu_issue_ctrl #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [2:0]             in_F,
    input  logic [31:0]            in_A,
    input  logic [31:0]            in_B,
    output logic [31:0]            alu_A,
    output logic [31:0]            alu_B,
    output logic [2:0]             alu_F,
    input  logic [31:0]            alu_Y,
    input  logic                   alu_Zero,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_Y,
    output logic                   out_Zero,
    output logic [2:0]             out_F,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef struct packed {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
    } req_t;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        HOLD
    } state_t;

    state_t        state;
    state_t        state_nxt;
    req_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    logic          capture;
    logic          release_res;

    assign in_ready = (count != FULL);
    assign push     = in_valid && in_ready;

    always_ff @(posedge Clock) begin
        if (push) begin
            mem[wr_ptr] <= {in_F, in_A, in_B};
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Pop decisions use the registered count, so a same-cycle push is never bypassed.
    always_comb begin
        state_nxt   = state;
        pop         = 1'b0;
        capture     = 1'b0;
        release_res = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop       = 1'b1;
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                capture   = 1'b1;
                state_nxt = HOLD;
            end
            HOLD: begin
                if (out_valid && out_ready) begin
                    release_res = 1'b1;
                    if (count != '0) begin
                        pop       = 1'b1;
                        state_nxt = EXEC;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            alu_A <= '0;
            alu_B <= '0;
            alu_F <= '0;
        end else if (pop) begin
            {alu_F, alu_A, alu_B} <= mem[rd_ptr];
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            out_valid <= 1'b0;
            out_Y     <= '0;
            out_Zero  <= 1'b0;
            out_F     <= '0;
        end else if (capture) begin
            out_valid <= 1'b1;
            out_Y     <= alu_Y;
            out_Zero  <= alu_Zero;
            out_F     <= alu_F;
        end else if (release_res) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl with a behavioural ALU attached to alu_*.
module tb_alu_issue_ctrl;

    localparam int unsigned DEPTH = 4;

    logic        Clock     = 1'b0;
    logic        Reset     = 1'b1;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b0;
    logic [2:0]  in_F      = '0;
    logic [31:0] in_A      = '0;
    logic [31:0] in_B      = '0;
    logic        in_ready;
    logic [31:0] alu_A;
    logic [31:0] alu_B;
    logic [2:0]  alu_F;
    logic [31:0] alu_Y;
    logic        alu_Zero;
    logic        out_valid;
    logic [31:0] out_Y;
    logic        out_Zero;
    logic [2:0]  out_F;
    logic [2:0]  count;

    int unsigned total = 0;
    int unsigned bad   = 0;
    int          cyc   = 0;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] y;
        logic        zero;
        int          cyc;
    } res_t;

    res_t exp_q[$];
    res_t got_q[$];

    function automatic logic [31:0] alu_fn(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        case (f)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a + b;
            3'b110:  return a - b;
            3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    assign alu_Y    = alu_fn(alu_F, alu_A, alu_B);
    assign alu_Zero = (alu_Y == 32'd0);

    alu_issue_ctrl #(.DEPTH(DEPTH)) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_F      (in_F),
        .in_A      (in_A),
        .in_B      (in_B),
        .alu_A     (alu_A),
        .alu_B     (alu_B),
        .alu_F     (alu_F),
        .alu_Y     (alu_Y),
        .alu_Zero  (alu_Zero),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_Y     (out_Y),
        .out_Zero  (out_Zero),
        .out_F     (out_F),
        .count     (count)
    );

    always #5 Clock = ~Clock;

    always @(posedge Clock) cyc <= cyc + 1;

    // Accepted requests feed the expected queue; handshaken results feed the got queue.
    always @(negedge Clock) begin : monitor
        res_t er;
        res_t gr;
        if (!Reset && in_valid && in_ready) begin
            er.f    = in_F;
            er.y    = alu_fn(in_F, in_A, in_B);
            er.zero = (er.y == 32'd0);
            er.cyc  = cyc;
            exp_q.push_back(er);
        end
        if (!Reset && out_valid && out_ready) begin
            gr.f    = out_F;
            gr.y    = out_Y;
            gr.zero = out_Zero;
            gr.cyc  = cyc;
            got_q.push_back(gr);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Leaves in_valid asserted so callers can push back-to-back.
    task automatic push_one(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, output bit ok);
        in_valid = 1'b1;
        in_F     = f;
        in_A     = a;
        in_B     = b;
        ok       = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (in_ready === 1'b1) begin
                ok = 1'b1;
                tick();
                break;
            end
            tick();
        end
    endtask

    task automatic wait_got(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (got_q.size() >= n) break;
            tick();
        end
        if (got_q.size() >= n) ok = 1'b1;
    endtask

    task automatic test_reset();
        tick();
        tick();
        total++;
        if (count !== 3'd0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_fifo got count=%0d in_ready=%b exp count=0 in_ready=1", count, in_ready);
        end
        total++;
        if (alu_A !== 32'd0 || alu_B !== 32'd0 || alu_F !== 3'd0) begin
            bad++;
            $display("FAIL reset_alu got A=%h B=%h F=%h exp all zero", alu_A, alu_B, alu_F);
        end
        total++;
        if (out_valid !== 1'b0 || out_Y !== 32'd0 || out_Zero !== 1'b0 || out_F !== 3'd0) begin
            bad++;
            $display("FAIL reset_out got v=%b Y=%h Z=%b F=%h exp all zero", out_valid, out_Y, out_Zero, out_F);
        end
    endtask

    task automatic test_single_add();
        res_t e;
        res_t g;
        Reset     = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_F      = 3'b010;
        in_A      = 32'h5;
        in_B      = 32'h3;
        tick();
        in_valid = 1'b0;
        total++;
        if (count !== 3'd1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL add_push got count=%0d v=%b exp count=1 v=0", count, out_valid);
        end
        tick();
        total++;
        if (alu_A !== 32'h5 || alu_B !== 32'h3 || alu_F !== 3'b010 || out_valid !== 1'b0 || count !== 3'd0) begin
            bad++;
            $display("FAIL add_pop got A=%h B=%h F=%h v=%b count=%0d exp 5 3 2 0 0", alu_A, alu_B, alu_F, out_valid, count);
        end
        tick();
        total++;
        if (out_valid !== 1'b1 || out_Y !== 32'h8 || out_Zero !== 1'b0 || out_F !== 3'b010) begin
            bad++;
            $display("FAIL add_result got v=%b Y=%h Z=%b F=%h exp 1 00000008 0 2", out_valid, out_Y, out_Zero, out_F);
        end
        tick();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL add_release got v=%b exp 0", out_valid);
        end
        while (exp_q.size() != 0 && got_q.size() != 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            total++;
            if (g.f !== e.f || g.y !== e.y || g.zero !== e.zero) begin
                bad++;
                $display("FAIL add_sb got F=%h Y=%h Z=%b exp F=%h Y=%h Z=%b", g.f, g.y, g.zero, e.f, e.y, e.zero);
            end
        end
        total++;
        if (exp_q.size() != 0 || got_q.size() != 0) begin
            bad++;
            $display("FAIL add_left got exp_left=%0d got_left=%0d exp 0 0", exp_q.size(), got_q.size());
        end
    endtask

    task automatic test_sub_zero();
        res_t e;
        res_t g;
        bit   ok;
        out_ready = 1'b1;
        push_one(3'b110, 32'hA, 32'hA, ok);
        in_valid = 1'b0;
        wait_got(1, 20, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL sub_timeout got results=%0d exp 1", got_q.size());
        end else begin
            total++;
            if (got_q[0].y !== 32'd0 || got_q[0].zero !== 1'b1 || got_q[0].f !== 3'b110) begin
                bad++;
                $display("FAIL sub_zero got Y=%h Z=%b F=%h exp 00000000 1 6", got_q[0].y, got_q[0].zero, got_q[0].f);
            end
        end
        while (exp_q.size() != 0 && got_q.size() != 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            total++;
            if (g.f !== e.f || g.y !== e.y || g.zero !== e.zero) begin
                bad++;
                $display("FAIL sub_sb got F=%h Y=%h Z=%b exp F=%h Y=%h Z=%b", g.f, g.y, g.zero, e.f, e.y, e.zero);
            end
        end
        total++;
        if (exp_q.size() != 0 || got_q.size() != 0) begin
            bad++;
            $display("FAIL sub_left got exp_left=%0d got_left=%0d exp 0 0", exp_q.size(), got_q.size());
        end
    endtask

    task automatic test_full();
        res_t        e;
        res_t        g;
        bit          ok;
        logic [2:0]  fs [6];
        logic [31:0] as [6];
        logic [31:0] bs [6];
        fs = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b010};
        as = '{32'h10, 32'h30, 32'hF0F0, 32'h0100, 32'h5, 32'h99};
        bs = '{32'h01, 32'h07, 32'h0FF0, 32'h0011, 32'h4, 32'h01};
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_F     = fs[i];
            in_A     = as[i];
            in_B     = bs[i];
            tick();
            if (i == 4) begin
                total++;
                if (count !== 3'd4 || in_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL full_level got count=%0d in_ready=%b exp 4 0", count, in_ready);
                end
            end
        end
        in_valid = 1'b0;
        total++;
        if (count !== 3'd4 || exp_q.size() != 5 || got_q.size() != 0) begin
            bad++;
            $display("FAIL full_ignore got count=%0d accepted=%0d results=%0d exp 4 5 0", count, exp_q.size(), got_q.size());
        end
        out_ready = 1'b1;
        wait_got(5, 40, ok);
        for (int i = 0; i < 6; i++) tick();
        total++;
        if (!ok || count !== 3'd0) begin
            bad++;
            $display("FAIL full_drain got results=%0d count=%0d exp 5 0", got_q.size(), count);
        end
        while (exp_q.size() != 0 && got_q.size() != 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            total++;
            if (g.f !== e.f || g.y !== e.y || g.zero !== e.zero) begin
                bad++;
                $display("FAIL full_sb got F=%h Y=%h Z=%b exp F=%h Y=%h Z=%b", g.f, g.y, g.zero, e.f, e.y, e.zero);
            end
        end
        total++;
        if (exp_q.size() != 0 || got_q.size() != 0) begin
            bad++;
            $display("FAIL full_left got exp_left=%0d got_left=%0d exp 0 0", exp_q.size(), got_q.size());
        end
    endtask

    task automatic test_backpressure();
        res_t        e;
        res_t        g;
        bit          ok;
        logic [31:0] sy;
        logic        sz;
        logic [2:0]  sf;
        out_ready = 1'b0;
        push_one(3'b010, 32'h7FFFFFFF, 32'h1, ok);
        in_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        sy = out_Y;
        sz = out_Zero;
        sf = out_F;
        total++;
        if (!ok || sy !== 32'h80000000 || sz !== 1'b0 || sf !== 3'b010) begin
            bad++;
            $display("FAIL bp_first got v=%b Y=%h Z=%b F=%h exp 1 80000000 0 2", out_valid, sy, sz, sf);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            total++;
            if (out_valid !== 1'b1 || out_Y !== sy || out_Zero !== sz || out_F !== sf) begin
                bad++;
                $display("FAIL bp_hold cycle %0d got v=%b Y=%h Z=%b F=%h exp 1 %h %b %h", i, out_valid, out_Y, out_Zero, out_F, sy, sz, sf);
            end
        end
        out_ready = 1'b1;
        tick();
        total++;
        if (out_valid !== 1'b0 || got_q.size() != 1) begin
            bad++;
            $display("FAIL bp_release got v=%b results=%0d exp 0 1", out_valid, got_q.size());
        end
        while (exp_q.size() != 0 && got_q.size() != 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            total++;
            if (g.f !== e.f || g.y !== e.y || g.zero !== e.zero) begin
                bad++;
                $display("FAIL bp_sb got F=%h Y=%h Z=%b exp F=%h Y=%h Z=%b", g.f, g.y, g.zero, e.f, e.y, e.zero);
            end
        end
        total++;
        if (exp_q.size() != 0 || got_q.size() != 0) begin
            bad++;
            $display("FAIL bp_left got exp_left=%0d got_left=%0d exp 0 0", exp_q.size(), got_q.size());
        end
    endtask

    task automatic test_back_to_back();
        res_t        e;
        res_t        g;
        bit          ok;
        bit          all_ok;
        bit          gap_ok;
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        out_ready = 1'b1;
        all_ok    = 1'b1;
        for (int i = 0; i < 9; i++) begin
            case (i % 3)
                0: begin f = 3'b000; a = 32'hFFFF0000; b = 32'h0F0F0F0F + i; end
                1: begin f = 3'b001; a = i << 4; b = 32'h00000F00; end
                default: begin f = 3'b111; a = 32'hFFFFFFFF; b = (i == 5) ? 32'hFFFFFFFE : 32'h1; end
            endcase
            push_one(f, a, b, ok);
            all_ok &= ok;
        end
        in_valid = 1'b0;
        wait_got(9, 60, ok);
        total++;
        if (!ok || !all_ok) begin
            bad++;
            $display("FAIL b2b_timeout got results=%0d pushes_ok=%b exp 9 1", got_q.size(), all_ok);
        end else begin
            total++;
            if (got_q[0].y !== 32'h0F0F0000 || got_q[2].y !== 32'h1 || got_q[5].y !== 32'h0 || got_q[5].zero !== 1'b1) begin
                bad++;
                $display("FAIL b2b_const got %h %h %h/%b exp 0F0F0000 00000001 00000000/1", got_q[0].y, got_q[2].y, got_q[5].y, got_q[5].zero);
            end
            gap_ok = 1'b1;
            for (int k = 1; k < 9; k++) begin
                if (got_q[k].cyc - got_q[k-1].cyc != 2) gap_ok = 1'b0;
            end
            total++;
            if (!gap_ok) begin
                bad++;
                $display("FAIL b2b_rate got first gap=%0d exp every gap 2", got_q[1].cyc - got_q[0].cyc);
            end
        end
        while (exp_q.size() != 0 && got_q.size() != 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            total++;
            if (g.f !== e.f || g.y !== e.y || g.zero !== e.zero) begin
                bad++;
                $display("FAIL b2b_sb got F=%h Y=%h Z=%b exp F=%h Y=%h Z=%b", g.f, g.y, g.zero, e.f, e.y, e.zero);
            end
        end
        total++;
        if (exp_q.size() != 0 || got_q.size() != 0 || count !== 3'd0) begin
            bad++;
            $display("FAIL b2b_left got exp_left=%0d got_left=%0d count=%0d exp 0 0 0", exp_q.size(), got_q.size(), count);
        end
    endtask

    task automatic test_reset_hold();
        res_t e;
        res_t g;
        bit   ok;
        bit   quiet;
        out_ready = 1'b0;
        push_one(3'b010, 32'h100, 32'h1, ok);
        push_one(3'b001, 32'h200, 32'h2, ok);
        push_one(3'b110, 32'h300, 32'h3, ok);
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1 || count !== 3'd2) begin
            bad++;
            $display("FAIL rst_setup got v=%b count=%0d exp 1 2", out_valid, count);
        end
        #2;
        Reset    = 1'b1;
        in_valid = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0 || count !== 3'd0 || alu_A !== 32'd0 || out_Y !== 32'd0) begin
            bad++;
            $display("FAIL rst_async got v=%b count=%0d A=%h Y=%h exp 0 0 0 0", out_valid, count, alu_A, out_Y);
        end
        exp_q.delete();
        got_q.delete();
        tick();
        tick();
        total++;
        if (count !== 3'd0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL rst_push_ignored got count=%0d v=%b exp 0 0", count, out_valid);
        end
        Reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        quiet     = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid !== 1'b0) quiet = 1'b0;
        end
        total++;
        if (!quiet || got_q.size() != 0) begin
            bad++;
            $display("FAIL rst_stale got quiet=%b results=%0d exp 1 0", quiet, got_q.size());
        end
        push_one(3'b010, 32'h21, 32'h21, ok);
        in_valid = 1'b0;
        wait_got(1, 20, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL rst_after_timeout got results=%0d exp 1", got_q.size());
        end
        while (exp_q.size() != 0 && got_q.size() != 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            total++;
            if (g.f !== e.f || g.y !== e.y || g.zero !== e.zero) begin
                bad++;
                $display("FAIL rst_sb got F=%h Y=%h Z=%b exp F=%h Y=%h Z=%b", g.f, g.y, g.zero, e.f, e.y, e.zero);
            end
        end
        total++;
        if (exp_q.size() != 0 || got_q.size() != 0) begin
            bad++;
            $display("FAIL rst_left got exp_left=%0d got_left=%0d exp 0 0", exp_q.size(), got_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_sub_zero();
        test_full();
        test_backpressure();
        test_back_to_back();
        test_reset_hold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
